seg_scan: RTL and testbench
===========================

# seg_scan

Four-digit multiplexed seven-segment display driver. It sits directly downstream of the display clock divider and uses that block's divided output, `clk_out_disp`, as a scan-rate input. `disp_clk` is sampled in the `clk` domain and treated purely as an enable, never as a clock. On every rising edge of `disp_clk` the driver advances to the next digit, inserting an anode-off guard gap to suppress ghosting. New display data is double-buffered so that each frame is tear-free.

## Interface
- `GAP_CYC`, default 16: number of `clk` cycles all anodes stay off between digits. Legal range 1..255.
- `LZB`, default 1: 1 enables leading-zero blanking; 0 shows all digits.
- `clk`  in  1: system clock; the same clock that drives the divider.
- `rst`  in  1: reset, asynchronous, active-high.
- `disp_clk`  in  1: divided display clock from the divider. It is synchronous to `clk` and used as a level to be edge-detected.
- `data`  in  16: four hex nibbles. `[15:12]` is digit 3 (leftmost) and `[3:0]` is digit 0 (rightmost).
- `dp_in`  in  4: decimal-point request per digit, bit i for digit i.
- `data_vld`  in  1: single-cycle strobe that captures `data` and `dp_in` into the pending buffer.
- `seg_n`  out  7: segments, active-low. Bit 0 = a through bit 6 = g.
- `dp_n`  out  1: decimal point, active-low.
- `an_n`  out  4: digit anodes, active-low. Bit i enables digit i.
- `frame_done`  out  1: one-cycle pulse when pending data is transferred to the shadow buffer.

## Operation
- Tick detection:
  - `disp_q` registers `disp_clk`.
  - `tick = disp_clk & ~disp_q`, so there is one tick per divider period.
- Pending buffer:
  - `data_vld` loads `pend_data`/`pend_dp` and sets `pend_full`.
  - Repeated strobes overwrite; the last one wins.
- Shadow buffer (`shd_data`, `shd_dp`): the only source for display output.
- Digit index `idx`, 2 bits, wraps 3 -> 0.
- FSM states are IDLE, GAP and SHOW.
  - IDLE: entered on reset. All outputs are off. A tick moves to GAP.
  - SHOW: a tick moves to GAP.
  - GAP: counts down; when `cnt == 0` it moves to SHOW.
- On a tick in IDLE or SHOW, in the same edge:
  - `an_n <= 4'hF`, `seg_n <= 7'h7F`, `dp_n <= 1`.
  - `cnt <= GAP_CYC-1`.
  - `idx <= idx+1`.
- Frame boundary:
  - Condition: the new `idx` is 0 and `pend_full` is 1.
  - Action: `shd <= pend`, `pend_full <= 0`, `frame_done <= 1` for one cycle.
- Entering SHOW:
  - `an_n <= ~(4'b1 << idx)`.
  - `seg_n <= decode(shd_data[idx])`.
  - `dp_n <= ~shd_dp[idx]`.
- Decode table (hex, bit order gfedcba, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking (`LZB=1`):
  - Digit i (i ≥ 1) is blanked when its nibble and all higher nibbles are 0.
  - A blanked digit drives `seg_n = 7'h7F` while its anode is still asserted.
  - Digit 0 is never blanked.
  - `dp_n` is unaffected by blanking.

## Timing
- Reset values:
  - Outputs: `an_n=4'hF`, `seg_n=7'h7F`, `dp_n=1`, `frame_done=0`.
  - Internal: `idx=3`, `shd=0`, `pend=0`, `pend_full=0`, `disp_q=0`, `cnt=0`, state IDLE.
- Tick latency: a `disp_clk` rise is seen at cycle T, and `an_n` goes to F at the edge ending T.
- Guard gap: anodes stay off for exactly `GAP_CYC` cycles. The new digit appears at the edge ending T+`GAP_CYC`.
- `frame_done` asserts at the edge ending T, coincident with the idx 3 -> 0 advance.
- Tick during GAP is ignored. The integration constraint is `GAP_CYC < 2*DISP`, so this does not occur in a correct build.
- `data_vld` in the same cycle as a frame transfer:
  - Shadow takes the old pending value.
  - Pending takes the new value, and `pend_full` stays 1.
- Reset asserted mid-GAP or mid-SHOW: immediate return to the reset values. Pending data is lost.
- `disp_clk` stuck high or low: no ticks; the current digit holds indefinitely.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then drive `disp_clk` with period 40 and `GAP_CYC=4`:
  - First tick -> `an_n=F` for 4 cycles, then `an_n=4'b1110`.
  - With no data loaded, `seg_n=7'h40` ('0').
- `data_vld` with `data=16'h12AF`, `dp_in=4'b0100`:
  - `frame_done` pulses at the next idx 3 -> 0 advance.
  - Digits 0..3 show `seg_n` 0E, 08, 24, 79.
  - `dp_n=0` only while `an_n=4'b1011`.
- `LZB=1`, `data=16'h0050`:
  - Digits 3 and 2 show `seg_n=7F` with anode low.
  - Digit 1 shows 12 and digit 0 shows 40.
  - With `LZB=0`, digits 3 and 2 show 40.
- Strobe `data_vld` at idx=1 with 16'h1111, then at idx=2 with 16'h2222:
  - The frame shows 2222.
  - Exactly one `frame_done` pulse.
  - The digit shown at idx 1..3 before the boundary remains the old data.
- Strobe `data_vld` in the same cycle as a frame transfer:
  - Shadow gets the prior pending value.
  - The new value appears one frame later with a second `frame_done`.
- Assert `rst` during GAP, and separately during SHOW:
  - `an_n=F`, `seg_n=7F`, `dp_n=1`, `frame_done=0` immediately.
  - After release, the first tick displays digit 0.

Source files
------------

// File: rtl/seg_scan_if.sv
// Display-side bundle for seg_scan: scan enable and frame data in, segment/anode drive out.
interface seg_scan_if;
    logic        disp_clk;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic        data_vld;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    modport master (
        output disp_clk, data, dp_in, data_vld,
        input  seg_n, dp_n, an_n, frame_done
    );
    modport slave (
        input  disp_clk, data, dp_in, data_vld,
        output seg_n, dp_n, an_n, frame_done
    );
endinterface

// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment scanner: disp_clk rise advances the digit through an
// anode-off guard gap; display data is double-buffered and swapped only at frame start.
module seg_scan_digit #(
    parameter bit LZB = 1'b1,
    parameter int IDX = 0
) (
    input  logic [3:0] nib,
    input  logic       hi_zero,
    output logic [6:0] seg_n
);
    logic [6:0] glyph;

    always_comb begin
        glyph = 7'h7F;
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

    // Rightmost digit always shows so a zero value never renders fully dark
    assign seg_n = (LZB && (IDX != 0) && hi_zero) ? 7'h7F : glyph;
endmodule

module seg_scan #(
    parameter int unsigned GAP_CYC = 16,
    parameter bit          LZB     = 1'b1
) (
    input logic       clk,
    input logic       rst,
    seg_scan_if.slave bus
);
    localparam int NUM_DIG = 4;

    typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

    state_t                   state;
    logic                     disp_q;
    logic                     tick;
    logic [15:0]              pend_data;
    logic [3:0]               pend_dp;
    logic                     pend_full;
    logic [15:0]              shd_data;
    logic [3:0]               shd_dp;
    logic [1:0]               idx;
    logic [1:0]               idx_nxt;
    logic [7:0]               cnt;
    logic                     frame_xfer;
    logic [NUM_DIG-1:0]       hi_zero;
    logic [NUM_DIG-1:0][6:0]  dig_seg;

    assign tick       = bus.disp_clk & ~disp_q;
    assign idx_nxt    = idx + 2'd1;
    assign frame_xfer = tick && (state != GAP) && (idx_nxt == 2'd0) && pend_full;

    for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
        assign hi_zero[i] = (shd_data[15:4*i] == '0);
        seg_scan_digit #(.LZB(LZB), .IDX(i)) u_dig (
            .nib     (shd_data[4*i +: 4]),
            .hi_zero (hi_zero[i]),
            .seg_n   (dig_seg[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            disp_q         <= 1'b0;
            idx            <= 2'd3;
            cnt            <= '0;
            pend_data      <= '0;
            pend_dp        <= '0;
            pend_full      <= 1'b0;
            shd_data       <= '0;
            shd_dp         <= '0;
            bus.an_n       <= 4'hF;
            bus.seg_n      <= 7'h7F;
            bus.dp_n       <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            disp_q         <= bus.disp_clk;
            bus.frame_done <= 1'b0;

            if (frame_xfer) begin
                shd_data       <= pend_data;
                shd_dp         <= pend_dp;
                pend_full      <= 1'b0;
                bus.frame_done <= 1'b1;
            end
            // A strobe coincident with the swap refills pending after shadow took the old value
            if (bus.data_vld) begin
                pend_data <= bus.data;
                pend_dp   <= bus.dp_in;
                pend_full <= 1'b1;
            end

            case (state)
                IDLE, SHOW: begin
                    if (tick) begin
                        state     <= GAP;
                        bus.an_n  <= 4'hF;
                        bus.seg_n <= 7'h7F;
                        bus.dp_n  <= 1'b1;
                        cnt       <= 8'(GAP_CYC - 1);
                        idx       <= idx_nxt;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state     <= SHOW;
                        bus.an_n  <= ~(4'b0001 << idx);
                        bus.seg_n <= dig_seg[idx];
                        bus.dp_n  <= ~shd_dp[idx];
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// Randomized bench for seg_scan: two instances (blanking on/off) checked every cycle against
// a digit/frame-level model of the display.
module tb_seg_scan;
    localparam int G    = 4;
    localparam int PER  = 40;
    localparam int HALF = 20;
    localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg_scan_if bus1();
    seg_scan_if bus0();

    seg_scan #(.GAP_CYC(G), .LZB(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    seg_scan #(.GAP_CYC(G), .LZB(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    int checks   = 0;
    int failures = 0;

    // display model
    int          cyc = 0;
    bit          started;
    int          tick_cyc;
    int          ntick;
    logic [15:0] frm, pnd;
    logic [3:0]  frm_dp, pnd_dp;
    bit          pfull;
    bit          prev_disp;
    int          disp_cnt;
    int          stuck;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg1, exp_seg0;
    logic        exp_dp, exp_fd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit disp_level();
        return (disp_cnt % PER) >= HALF;
    endfunction

    function automatic bit showing();
        return started && (cyc - 1 - tick_cyc >= G);
    endfunction

    task automatic drive(input bit lvl, input bit vld, input logic [15:0] d, input logic [3:0] dp);
        bus1.disp_clk = lvl; bus1.data_vld = vld; bus1.data = d; bus1.dp_in = dp;
        bus0.disp_clk = lvl; bus0.data_vld = vld; bus0.data = d; bus0.dp_in = dp;
    endtask

    task automatic check_off(input string tag);
        chk({tag, "_an1"}, 32'(bus1.an_n), 32'hF);
        chk({tag, "_seg1"}, 32'(bus1.seg_n), 32'h7F);
        chk({tag, "_dp1"}, 32'(bus1.dp_n), 32'h1);
        chk({tag, "_fd1"}, 32'(bus1.frame_done), 32'h0);
        chk({tag, "_an0"}, 32'(bus0.an_n), 32'hF);
        chk({tag, "_fd0"}, 32'(bus0.frame_done), 32'h0);
    endtask

    // One clk cycle: inputs applied after a falling edge, outputs checked at the next one.
    task automatic run_cyc(input bit vld, input logic [15:0] d, input logic [3:0] dp);
        bit         lvl, tk, blank;
        int         dig;
        logic [3:0] one, nib;
        lvl = disp_level();
        drive(lvl, vld, d, dp);
        tk = lvl && !prev_disp;
        prev_disp = lvl;
        exp_fd = 1'b0;
        if (tk) begin
            ntick++;
            started  = 1'b1;
            tick_cyc = cyc;
            if ((ntick - 1) % 4 == 0 && pfull) begin
                frm = pnd; frm_dp = pnd_dp; pfull = 1'b0; exp_fd = 1'b1;
            end
        end
        if (vld) begin
            pnd = d; pnd_dp = dp; pfull = 1'b1;
        end
        if (!started || (cyc - tick_cyc < G)) begin
            exp_an = 4'hF; exp_seg1 = 7'h7F; exp_seg0 = 7'h7F; exp_dp = 1'b1;
        end else begin
            dig      = (ntick - 1) % 4;
            one      = 4'b0001;
            exp_an   = ~(one << dig);
            nib      = frm[4*dig +: 4];
            blank    = (dig != 0) && ((frm >> (4*dig)) == 16'h0);
            exp_seg0 = DEC[nib];
            exp_seg1 = blank ? 7'h7F : DEC[nib];
            exp_dp   = ~frm_dp[dig];
        end
        @(posedge clk);
        @(negedge clk);
        chk("an1", 32'(bus1.an_n), 32'(exp_an));
        chk("seg1", 32'(bus1.seg_n), 32'(exp_seg1));
        chk("dp1", 32'(bus1.dp_n), 32'(exp_dp));
        chk("fd1", 32'(bus1.frame_done), 32'(exp_fd));
        chk("an0", 32'(bus0.an_n), 32'(exp_an));
        chk("seg0", 32'(bus0.seg_n), 32'(exp_seg0));
        chk("dp0", 32'(bus0.dp_n), 32'(exp_dp));
        chk("fd0", 32'(bus0.frame_done), 32'(exp_fd));
        cyc++;
        if (stuck > 0) stuck--;
        else disp_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cyc(1'b0, 16'h0, 4'h0);
    endtask

    task automatic do_reset(input string tag, input int hold);
        #2 rst = 1'b1;
        #1 check_off(tag);
        drive(1'b0, 1'b0, 16'h0, 4'h0);
        repeat (hold) @(negedge clk);
        check_off(tag);
        rst = 1'b0;
        started = 1'b0; ntick = 0; tick_cyc = 0;
        frm = '0; frm_dp = '0; pnd = '0; pnd_dp = '0; pfull = 1'b0;
        prev_disp = 1'b0; disp_cnt = 0; stuck = 0;
    endtask

    task automatic wait_digit(input int k);
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (showing() && ((ntick - 1) % 4 == k)) found = 1'b1;
            else idle(1);
        end
        chk("wait_digit", 32'(found), 32'h1);
    endtask

    task automatic wait_frame_tick();
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (disp_level() && !prev_disp && (ntick % 4 == 0)) found = 1'b1;
            else idle(1);
        end
        chk("wait_frame", 32'(found), 32'h1);
    endtask

    task automatic wait_state(input bit want_show);
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (started && ((exp_an != 4'hF) == want_show)) found = 1'b1;
            else idle(1);
        end
        chk("wait_state", 32'(found), 32'h1);
    endtask

    initial begin
        logic [15:0] r, d;
        logic [3:0]  dp;
        bit          vld;
        drive(1'b0, 1'b0, 16'h0, 4'h0);
        do_reset("rst0", 3);

        idle(200);                                   // blank data shows '0' on digit 0 scans
        run_cyc(1'b1, 16'h12AF, 4'b0100);
        idle(400);
        run_cyc(1'b1, 16'h0050, 4'b0000);            // leading-zero blanking
        idle(400);

        wait_digit(1);
        run_cyc(1'b1, 16'h1111, 4'b0001);
        wait_digit(2);
        run_cyc(1'b1, 16'h2222, 4'b0010);            // last strobe wins
        idle(400);

        run_cyc(1'b1, 16'h3333, 4'b1000);
        wait_frame_tick();
        run_cyc(1'b1, 16'h4444, 4'b0001);            // strobe coincident with swap
        idle(400);

        run_cyc(1'b1, 16'h5678, 4'b1111);
        wait_state(1'b0);
        do_reset("rst_gap", 2);
        idle(200);

        run_cyc(1'b1, 16'h9ABC, 4'b0110);
        idle(200);
        wait_state(1'b1);
        run_cyc(1'b1, 16'hDEF0, 4'b1001);
        do_reset("rst_show", 2);
        idle(200);

        for (int i = 0; i < 2000; i++) begin
            vld = ($urandom_range(0, 29) == 0);
            r   = 16'($urandom);
            d   = r >> (4 * $urandom_range(0, 3));
            dp  = 4'($urandom);
            if (stuck == 0 && $urandom_range(0, 299) == 0) stuck = $urandom_range(50, 150);
            run_cyc(vld, d, dp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
